// File: rtl/ama_riscv_fetch_queue_pkg.sv
// Shared types and constants for the fetch queue and its FIFOs.
package ama_riscv_fetch_queue_pkg;

    localparam int unsigned ARCH_WIDTH = 32;

    typedef logic [ARCH_WIDTH-1:0] arch_width_t;

    typedef struct packed {
        arch_width_t pc;
        arch_width_t inst;
    } fetch_entry_t;

    localparam arch_width_t INST_NOP      = 32'h0000_0013;
    localparam arch_width_t FETCH_RST_VEC = 32'h0000_0000;

    // Fetch PCs are always word aligned; the low two bits are forced to zero.
    function automatic arch_width_t pc_align(input arch_width_t pc);
        return pc & ~arch_width_t'(3);
    endfunction

endpackage

// File: rtl/ama_riscv_fetch_queue_sync_fifo.sv
// Synchronous FIFO with flush and occupancy; head is a combinational read of the oldest entry.
module ama_riscv_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         data,
    output logic [WIDTH-1:0]         head_c,
    output logic [$clog2(DEPTH):0]   occ
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot, so a full FIFO may push and pop in the same cycle.
    always_comb begin
        do_pop  = 1'b0;
        do_push = 1'b0;
        do_pop  = pop && (occ != CW'(0)) && !flush;
        do_push = push && !flush && ((occ != CW'(DEPTH)) || do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            occ <= occ + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr] <= data;
    end

    assign head_c = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            assert (!(push && (occ == CW'(DEPTH)) && !pop))
                else $error("sync_fifo: push while full");
        end
    end

endmodule

// File: rtl/ama_riscv_fetch_queue.sv
// Fetch queue between IMEM and the decoder: sequential fetch, in-order buffering, redirect flush.
// Optional combinational response bypass to the decoder: define FETCH_QUEUE_BYPASS_EN.
module ama_riscv_fetch_queue
    import ama_riscv_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH        = 2,
    parameter arch_width_t RESET_VECTOR = FETCH_RST_VEC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] inst_dec,
    output logic [31:0] pc_dec
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;
    localparam int unsigned EW = $bits(fetch_entry_t);

    arch_width_t   fetch_pc;
    logic [CW-1:0] occ;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] tag_occ;
    arch_width_t   tag_head;
    logic [EW-1:0] q_head_raw;
    fetch_entry_t  q_head;
    fetch_entry_t  rsp_entry;
    fetch_entry_t  head_sel;
    logic [SW-1:0] fill_sum;
    logic [SW-1:0] flight_sum;
    logic          req_fire;
    logic          rsp_drop;
    logic          rsp_take;
    logic          bypass_hit;
    logic          q_push;
    logic          q_pop;

    // Issue gating, response classification and decoder-facing head selection.
    always_comb begin
        fill_sum   = SW'(occ) + SW'(out_cnt);
        flight_sum = SW'(out_cnt) + SW'(drop_cnt);
        imem_req_valid = !rst && !redirect_valid
                         && (fill_sum < SW'(DEPTH)) && (flight_sum < SW'(DEPTH));
        req_fire  = imem_req_valid && imem_req_ready;
        rsp_drop  = imem_rsp_valid && (drop_cnt != CW'(0));
        rsp_take  = imem_rsp_valid && (drop_cnt == CW'(0)) && !redirect_valid;
        q_head    = fetch_entry_t'(q_head_raw);
        rsp_entry = '{pc: tag_head, inst: imem_rsp_data};
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_hit = (occ == CW'(0)) && (drop_cnt == CW'(0)) && !redirect_valid && imem_rsp_valid;
`else
        bypass_hit = 1'b0;
`endif
        dec_valid = (occ != CW'(0)) || bypass_hit;
        head_sel  = bypass_hit ? rsp_entry : q_head;
        inst_dec  = dec_valid ? head_sel.inst : INST_NOP;
        pc_dec    = dec_valid ? head_sel.pc : 32'h0;
        q_pop     = (occ != CW'(0)) && dec_ready && !redirect_valid;
        q_push    = rsp_take && !(bypass_hit && dec_ready);
    end

    assign imem_req_addr = fetch_pc;

    // Fetch PC and in-flight accounting; a redirect turns every outstanding request into a drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_VECTOR;
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= pc_align(redirect_pc);
            out_cnt  <= '0;
            drop_cnt <= drop_cnt + out_cnt - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + 32'd4;
            out_cnt  <= out_cnt + CW'(req_fire) - CW'(rsp_take);
            drop_cnt <= drop_cnt - CW'(rsp_drop);
        end
    end

    ama_riscv_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_entry_q (
        .clk    (clk),
        .rst    (rst),
        .push   (q_push),
        .pop    (q_pop),
        .flush  (redirect_valid),
        .data   (EW'(rsp_entry)),
        .head_c (q_head_raw),
        .occ    (occ)
    );

    // PCs of live outstanding requests, oldest first; dropped responses never reach it.
    ama_riscv_sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_tag_q (
        .clk    (clk),
        .rst    (rst),
        .push   (req_fire),
        .pop    (rsp_take),
        .flush  (redirect_valid),
        .data   (fetch_pc),
        .head_c (tag_head),
        .occ    (tag_occ)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (tag_occ == out_cnt) else $error("fetch_queue: tag queue out of sync");
        end
    end

endmodule

// File: tb/tb_ama_riscv_fetch_queue.sv
// Directed bench for ama_riscv_fetch_queue with a fixed-latency in-order IMEM model.
module tb_ama_riscv_fetch_queue;

    localparam int unsigned DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] inst_dec;
    logic [31:0] pc_dec;

    int checks   = 0;
    int failures = 0;
    int imem_lat = 1;
    int ec       = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pq[$];
    logic [31:0] req_log[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_inst[$];

    ama_riscv_fetch_queue #(
        .DEPTH        (DEPTH),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .inst_dec       (inst_dec),
        .pc_dec         (pc_dec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a + 32'h1000_0003;
    endfunction

    // IMEM model plus request/pop logs; responses come back imem_lat edges after the handshake.
    always @(posedge clk) begin
        ec = ec + 1;
        if (rst) begin
            pq.delete();
            req_log.delete();
            pop_pc.delete();
            pop_inst.delete();
        end else begin
            if (imem_rsp_valid && pq.size() > 0) void'(pq.pop_front());
            if (dec_valid && dec_ready && !redirect_valid) begin
                pop_pc.push_back(pc_dec);
                pop_inst.push_back(inst_dec);
            end
            if (imem_req_valid && imem_req_ready) begin
                pq.push_back('{addr: imem_req_addr, due: ec + imem_lat});
                req_log.push_back(imem_req_addr);
            end
        end
        if (pq.size() > 0 && pq[0].due == ec + 1) begin
            imem_rsp_valid <= 1'b1;
            imem_rsp_data  <= inst_of(pq[0].addr);
        end else begin
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'hDEAD_BEEF;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat);
        rst = 1'b1; imem_lat = lat; redirect_valid = 1'b0; redirect_pc = 32'h0;
        dec_ready = 1'b1; imem_req_ready = 1'b1;
        tick(2);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset(1);
        tick(4);
        rst = 1'b1;
        tick(1);
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
        checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL reset_dec_valid got=%b exp=0", dec_valid); end
        checks++; if (inst_dec !== 32'h0000_0013) begin failures++; $display("FAIL reset_inst_dec got=%h exp=00000013", inst_dec); end
        checks++; if (pc_dec !== 32'h0) begin failures++; $display("FAIL reset_pc_dec got=%h exp=0", pc_dec); end
        rst = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin failures++; $display("FAIL reset_first_req got=%b/%h exp=1/00000000", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_stream();
        do_reset(1);
        tick(14);
        checks++; if (req_log.size() < 3) begin failures++; $display("FAIL stream_req_count got=%0d exp>=3", req_log.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (req_log[i] !== 32'(4 * i)) begin failures++; $display("FAIL stream_req_addr[%0d] got=%h exp=%h", i, req_log[i], 32'(4 * i)); end
            end
        end
        checks++; if (pop_pc.size() < 3) begin failures++; $display("FAIL stream_pop_count got=%0d exp>=3", pop_pc.size()); end
        for (int i = 0; i < pop_pc.size(); i++) begin
            checks++; if (pop_pc[i] !== 32'(4 * i) || pop_inst[i] !== inst_of(32'(4 * i))) begin
                failures++; $display("FAIL stream_pop[%0d] got=%h/%h exp=%h/%h", i, pop_pc[i], pop_inst[i], 32'(4 * i), inst_of(32'(4 * i)));
            end
        end
    endtask

    task automatic test_stall();
        do_reset(1);
        dec_ready = 1'b0;
        tick(8);
        checks++; if (req_log.size() != 2) begin failures++; $display("FAIL stall_req_count got=%0d exp=2", req_log.size()); end
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_req_valid got=%b exp=0", imem_req_valid); end
        checks++; if (dec_valid !== 1'b1 || pc_dec !== 32'h0 || inst_dec !== inst_of(32'h0)) begin failures++; $display("FAIL stall_head got=%b/%h/%h exp=1/00000000/%h", dec_valid, pc_dec, inst_dec, inst_of(32'h0)); end
        tick(3);
        checks++; if (pc_dec !== 32'h0) begin failures++; $display("FAIL stall_head_stable got=%h exp=0", pc_dec); end
        dec_ready = 1'b1;
        tick(10);
        checks++; if (pop_pc.size() < 3 || req_log.size() < 3) begin failures++; $display("FAIL stall_resume_count got=%0d/%0d exp>=3/3", pop_pc.size(), req_log.size()); end
        else begin
            checks++; if (pop_pc[0] !== 32'h0 || pop_pc[1] !== 32'h4 || pop_pc[2] !== 32'h8) begin failures++; $display("FAIL stall_resume_pops got=%h,%h,%h exp=0,4,8", pop_pc[0], pop_pc[1], pop_pc[2]); end
            checks++; if (req_log[2] !== 32'h8) begin failures++; $display("FAIL stall_resume_req got=%h exp=8", req_log[2]); end
        end
    endtask

    task automatic test_redirect_drop();
        do_reset(3);
        tick(2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL drop_req_in_redirect got=%b exp=0", imem_req_valid); end
        tick(1);
        redirect_valid = 1'b0;
        #1;
        checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL drop_empty_after got=%b exp=0", dec_valid); end
        tick(20);
        checks++; if (req_log.size() < 3 || req_log[2] !== 32'h100) begin failures++; $display("FAIL drop_new_req got_size=%0d exp_addr=00000100", req_log.size()); end
        checks++; if (pop_pc.size() < 2) begin failures++; $display("FAIL drop_pop_count got=%0d exp>=2", pop_pc.size()); end
        for (int i = 0; i < pop_pc.size(); i++) begin
            checks++; if (pop_pc[i] !== 32'h100 + 32'(4 * i) || pop_inst[i] !== inst_of(32'h100 + 32'(4 * i))) begin
                failures++; $display("FAIL drop_pop[%0d] got=%h/%h exp=%h", i, pop_pc[i], pop_inst[i], 32'h100 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect_rsp_pop();
        do_reset(1);
        tick(2);
        checks++; if (dec_valid !== 1'b1 || pc_dec !== 32'h0 || imem_rsp_valid !== 1'b1) begin failures++; $display("FAIL rsppop_setup got=%b/%h/%b exp=1/00000000/1", dec_valid, pc_dec, imem_rsp_valid); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick(1);
        redirect_valid = 1'b0;
        #1;
        checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL rsppop_empty got=%b exp=0", dec_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin failures++; $display("FAIL rsppop_next_req got=%b/%h exp=1/00000200", imem_req_valid, imem_req_addr); end
        checks++; if (pop_pc.size() != 0) begin failures++; $display("FAIL rsppop_no_pop got=%0d exp=0", pop_pc.size()); end
        tick(12);
        checks++; if (pop_pc.size() < 2) begin failures++; $display("FAIL rsppop_pop_count got=%0d exp>=2", pop_pc.size()); end
        for (int i = 0; i < pop_pc.size(); i++) begin
            checks++; if (pop_pc[i] !== 32'h200 + 32'(4 * i)) begin failures++; $display("FAIL rsppop_pop[%0d] got=%h exp=%h", i, pop_pc[i], 32'h200 + 32'(4 * i)); end
        end
    endtask

    task automatic test_req_stall_wrap();
        int n;
        do_reset(1);
        tick(1);
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin failures++; $display("FAIL hold_addr[%0d] got=%b/%h exp=1/00000004", i, imem_req_valid, imem_req_addr); end
        end
        imem_req_ready = 1'b1;
        tick(1);
        checks++; if (req_log.size() != 2 || req_log[req_log.size() - 1] !== 32'h4) begin failures++; $display("FAIL hold_accept got_size=%0d exp=2 last=00000004", req_log.size()); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick(1);
        redirect_valid = 1'b0;
        n = req_log.size();
        tick(10);
        checks++; if (req_log.size() < n + 2) begin failures++; $display("FAIL wrap_req_count got=%0d exp>=%0d", req_log.size(), n + 2); end
        else begin
            checks++; if (req_log[n] !== 32'hFFFF_FFFC || req_log[n + 1] !== 32'h0) begin failures++; $display("FAIL wrap_addr got=%h,%h exp=fffffffc,00000000", req_log[n], req_log[n + 1]); end
        end
    endtask

    task automatic test_bypass_timing();
        logic        exp_valid;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc;
`ifdef FETCH_QUEUE_BYPASS_EN
        exp_valid = 1'b1; exp_inst = inst_of(32'h0); exp_pc = 32'h4;
`else
        exp_valid = 1'b0; exp_inst = 32'h0000_0013; exp_pc = 32'h0;
`endif
        do_reset(1);
        tick(1);
        checks++; if (imem_rsp_valid !== 1'b1) begin failures++; $display("FAIL byp_rsp_present got=%b exp=1", imem_rsp_valid); end
        checks++; if (dec_valid !== exp_valid || inst_dec !== exp_inst) begin failures++; $display("FAIL byp_rsp_cycle got=%b/%h exp=%b/%h", dec_valid, inst_dec, exp_valid, exp_inst); end
        tick(1);
        checks++; if (dec_valid !== 1'b1 || pc_dec !== exp_pc) begin failures++; $display("FAIL byp_next_cycle got=%b/%h exp=1/%h", dec_valid, pc_dec, exp_pc); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; imem_req_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drop();
        test_redirect_rsp_pop();
        test_req_stall_wrap();
        test_bypass_timing();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
